avgiq_capture_ctrl: RTL and testbench

Sequencer for the avgIQ snapshot path of the 512-channel packetizer. On a software start it selects one channel from the channelized I/Q stream, accumulates 2^LOG_NAVG consecutive samples of that channel, and writes each I/Q average to the avgIQ BRAM at an incrementing address. It stops after 2^ADDR_W points. A 32-bit status word carrying busy, done and the write address drives the avgIQ_addr readback register.

---
 rtl/avgiq_pkg.sv | 20 ++
 rtl/avgiq_capture_ctrl_if.sv | 16 +
 rtl/avgiq_accum.sv | 67 ++++++
 rtl/avgiq_capture_ctrl.sv | 145 ++++++++++++++
 tb/tb_avgiq_capture_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/avgiq_pkg.sv
// Shared types and constants for the avgIQ snapshot capture path.
package avgiq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STATUS_BUSY_BIT = 31;
  localparam int STATUS_DONE_BIT = 30;
  localparam int SAMPLE_W        = 16;
  localparam int CH_W            = 9;

  function automatic logic [31:0] pack_iq(input logic [SAMPLE_W-1:0] i_avg,
                                          input logic [SAMPLE_W-1:0] q_avg);
    return {i_avg, q_avg};
  endfunction

endpackage

// File: rtl/avgiq_capture_ctrl_if.sv
// Channelized I/Q stream in, avgIQ BRAM write port out.
interface avgiq_capture_ctrl_if #(parameter int ADDR_W = 9) ();
  import avgiq_pkg::*;

  logic                       s_valid;
  logic [CH_W-1:0]            s_ch;
  logic signed [SAMPLE_W-1:0] s_i;
  logic signed [SAMPLE_W-1:0] s_q;
  logic                       bram_we;
  logic [ADDR_W-1:0]          bram_addr;
  logic [31:0]                bram_din;

  modport master (output s_valid, s_ch, s_i, s_q, input bram_we, bram_addr, bram_din);
  modport slave  (input s_valid, s_ch, s_i, s_q, output bram_we, bram_addr, bram_din);

endinterface

// File: rtl/avgiq_accum.sv
// One averaging lane: accumulates 2^LOG_NAVG samples and registers the average.
// AVGIQ_ROUND_EN selects round-half-up with positive clamp instead of floor.
module avgiq_accum
  import avgiq_pkg::*;
#(
  parameter int LOG_NAVG = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       accept,
  input  logic                       last,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic signed [SAMPLE_W-1:0] avg
);

  localparam int AW = SAMPLE_W + LOG_NAVG;

  logic signed [AW-1:0]       acc_r;
  logic signed [AW-1:0]       sum_s;
  logic signed [SAMPLE_W-1:0] res_s;
  logic signed [SAMPLE_W-1:0] avg_r;

`ifdef AVGIQ_ROUND_EN
  localparam int RW = AW + 1;
  localparam logic [RW-1:0]        HALF = {{(RW-1){1'b0}}, 1'b1} << (LOG_NAVG - 1);
  localparam logic signed [RW-1:0] OVF  = RW'(64'sd32768 << LOG_NAVG);
  logic signed [RW-1:0] rsum_s;

  // Full sum plus half an LSB, clamped when the shifted value exceeds +32767.
  always_comb begin
    sum_s  = acc_r + {{LOG_NAVG{sample[SAMPLE_W-1]}}, sample};
    rsum_s = {sum_s[AW-1], sum_s} + HALF;
    if (rsum_s >= OVF) begin
      res_s = 16'sh7FFF;
    end else begin
      res_s = rsum_s[LOG_NAVG +: SAMPLE_W];
    end
  end
`else
  // Floor average: the arithmetic shift is just a bit slice of the sum.
  always_comb begin
    sum_s = acc_r + {{LOG_NAVG{sample[SAMPLE_W-1]}}, sample};
    res_s = sum_s[LOG_NAVG +: SAMPLE_W];
  end
`endif

  // Accumulator reloads on the completing sample, which also latches the average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      avg_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (accept) begin
      if (last) begin
        acc_r <= '0;
        avg_r <= res_s;
      end else begin
        acc_r <= sum_s;
      end
    end
  end

  assign avg = avg_r;

endmodule

// File: rtl/avgiq_capture_ctrl.sv
// avgIQ snapshot sequencer: one channel, 2^LOG_NAVG-sample averages, 2^ADDR_W BRAM points.
// Optional rounding in the averaging lanes is enabled with `define AVGIQ_ROUND_EN.
module avgiq_capture_ctrl
  import avgiq_pkg::*;
#(
  parameter int LOG_NAVG = 4,
  parameter int ADDR_W   = 9
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic                  start,
  input  logic                  clr,
  input  logic [CH_W-1:0]       sel_ch,
  avgiq_capture_ctrl_if.slave   bus,
  output logic [31:0]           status
);

  state_e                state_r;
  logic                  start_d_r;
  logic [CH_W-1:0]       ch_r;
  logic [LOG_NAVG-1:0]   smp_cnt_r;
  logic [ADDR_W-1:0]     pt_r;
  logic [ADDR_W-1:0]     addr_r;
  logic                  we_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  start_edge_s;
  logic                  go_s;
  logic                  accept_s;
  logic                  last_s;
  logic                  acc_clr_s;
  logic [SAMPLE_W-1:0]   avg_i_s;
  logic [SAMPLE_W-1:0]   avg_q_s;
  logic [31:0]           status_s;

  // Start edge, sample qualification and lane clear; clr overrides everything.
  always_comb begin
    start_edge_s = start & ~start_d_r;
    go_s         = start_edge_s & ~clr & (state_r != RUN);
    accept_s     = (state_r == RUN) & bus.s_valid & (bus.s_ch == ch_r) & ~clr;
    last_s       = &smp_cnt_r;
    acc_clr_s    = clr | go_s;
  end

  // Capture FSM; the point counter wraps to 0 exactly as the last point is written.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_r   <= IDLE;
      start_d_r <= 1'b1;
      ch_r      <= '0;
      smp_cnt_r <= '0;
      pt_r      <= '0;
      addr_r    <= '0;
      we_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      start_d_r <= start;
      we_r      <= 1'b0;
      if (clr) begin
        state_r   <= IDLE;
        smp_cnt_r <= '0;
        pt_r      <= '0;
        busy_r    <= 1'b0;
        done_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE, DONE: begin
            if (go_s) begin
              ch_r      <= sel_ch;
              smp_cnt_r <= '0;
              pt_r      <= '0;
              state_r   <= RUN;
              busy_r    <= 1'b1;
              done_r    <= 1'b0;
            end else begin
              state_r <= state_r;
            end
          end
          RUN: begin
            if (accept_s) begin
              if (last_s) begin
                smp_cnt_r <= '0;
                we_r      <= 1'b1;
                addr_r    <= pt_r;
                pt_r      <= pt_r + ADDR_W'(1);
                if (&pt_r) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                end else begin
                  state_r <= RUN;
                end
              end else begin
                smp_cnt_r <= smp_cnt_r + LOG_NAVG'(1);
              end
            end else begin
              state_r <= RUN;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  avgiq_accum #(.LOG_NAVG(LOG_NAVG)) u_acc_i (
    .clk    (user_clk),
    .rst_n  (user_rst_n),
    .clr    (acc_clr_s),
    .accept (accept_s),
    .last   (last_s),
    .sample (bus.s_i),
    .avg    (avg_i_s)
  );

  avgiq_accum #(.LOG_NAVG(LOG_NAVG)) u_acc_q (
    .clk    (user_clk),
    .rst_n  (user_rst_n),
    .clr    (acc_clr_s),
    .accept (accept_s),
    .last   (last_s),
    .sample (bus.s_q),
    .avg    (avg_q_s)
  );

  // Status word assembled purely from registered state.
  always_comb begin
    status_s                  = 32'h0000_0000;
    status_s[STATUS_BUSY_BIT] = busy_r;
    status_s[STATUS_DONE_BIT] = done_r;
    status_s[ADDR_W-1:0]      = pt_r;
  end

  assign bus.bram_we   = we_r;
  assign bus.bram_addr = addr_r;
  assign bus.bram_din  = pack_iq(avg_i_s, avg_q_s);
  assign status        = status_s;

endmodule

// File: tb/tb_avgiq_capture_ctrl.sv
// Directed bench for avgiq_capture_ctrl with a write scoreboard (LOG_NAVG=2, ADDR_W=2).
module tb_avgiq_capture_ctrl;

  localparam int LOG_NAVG = 2;
  localparam int ADDR_W   = 2;

  logic        user_clk = 1'b0;
  logic        user_rst_n;
  logic        start;
  logic        clr;
  logic [8:0]  sel_ch;
  logic [31:0] status;

  int total  = 0;
  int bad    = 0;
  int wr_cnt = 0;
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_e;

  avgiq_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  avgiq_capture_ctrl #(.LOG_NAVG(LOG_NAVG), .ADDR_W(ADDR_W)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .start      (start),
    .clr        (clr),
    .sel_ch     (sel_ch),
    .bus        (bus),
    .status     (status)
  );

  always #5 user_clk = ~user_clk;

  // Scoreboard: every write strobe must match the oldest expected {addr, din}.
  always @(negedge user_clk) begin
    if (user_rst_n && bus.bram_we) begin
      total++;
      wr_cnt++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write: got addr=%0h din=%h want no write", bus.bram_addr, bus.bram_din);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        total++;
        assert ({bus.bram_addr, bus.bram_din} === exp_e) else begin
          bad++;
          $error("FAIL write: got addr=%0h din=%h want addr=%0h din=%h",
                 bus.bram_addr, bus.bram_din, exp_e[ADDR_W+31:32], exp_e[31:0]);
        end
      end
    end
  end

  function automatic logic [15:0] model_avg(input int sum);
    int r;
`ifdef AVGIQ_ROUND_EN
    r = (sum + (1 << (LOG_NAVG - 1))) >>> LOG_NAVG;
    if (r > 32767) r = 32767;
`else
    r = sum >>> LOG_NAVG;
`endif
    return r[15:0];
  endfunction

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [8:0] ch, input int i, input int q);
    bus.s_valid = 1'b1;
    bus.s_ch    = ch;
    bus.s_i     = 16'(i);
    bus.s_q     = 16'(q);
    step();
    bus.s_valid = 1'b0;
  endtask

  task automatic do_start(input logic [8:0] ch);
    start = 1'b0;
    step();
    sel_ch = ch;
    start  = 1'b1;
    step();
    chk("busy_after_start", status, 32'h8000_0000);
    exp_addr = '0;
    wr_cnt   = 0;
  endtask

  // One point of four matching samples, optionally interleaved with other-channel noise.
  task automatic feed_point(input logic [8:0] ch, input int i0, input int i1, input int i2,
                            input int i3, input int q0, input int q1, input int q2,
                            input int q3, input bit noise);
    int iv[4];
    int qv[4];
    iv = '{i0, i1, i2, i3};
    qv = '{q0, q1, q2, q3};
    for (int k = 0; k < 4; k++) begin
      if (noise) send(ch + 9'd1, int'($urandom_range(1, 30000)), -int'($urandom_range(1, 30000)));
      if (k == 3) begin
        exp_q.push_back({exp_addr, model_avg(i0 + i1 + i2 + i3), model_avg(q0 + q1 + q2 + q3)});
        exp_addr = exp_addr + 2'd1;
      end
      send(ch, iv[k], qv[k]);
    end
  endtask

  // Stream cycling all 512 channels; channel 5 carries I=100, Q=-100.
  task automatic stream_capture(input bit noise);
    for (int rep = 0; rep < 16; rep++) begin
      for (int c = 0; c < 512; c++) begin
        bus.s_valid = 1'b1;
        bus.s_ch    = 9'(c);
        if (c == 5) begin
          bus.s_i = 16'sd100;
          bus.s_q = -16'sd100;
          if (rep % 4 == 3) exp_q.push_back({ADDR_W'(rep / 4), 32'h0064_FF9C});
        end else if (noise) begin
          bus.s_i = 16'($urandom);
          bus.s_q = 16'($urandom);
        end else begin
          bus.s_i = 16'sd0;
          bus.s_q = 16'sd0;
        end
        step();
      end
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    user_rst_n  = 1'b0;
    start       = 1'b1;
    clr         = 1'b0;
    sel_ch      = 9'd0;
    bus.s_valid = 1'b0;
    bus.s_ch    = 9'd0;
    bus.s_i     = 16'sd0;
    bus.s_q     = 16'sd0;
    exp_addr    = '0;
    step();
    step();
    chk("rst_status", status, 32'h0);
    chk("rst_we", bus.bram_we, 1'b0);
    chk("rst_addr", bus.bram_addr, 2'd0);
    chk("rst_din", bus.bram_din, 32'h0);

    // Start already high at reset release must not arm a capture.
    user_rst_n = 1'b1;
    step();
    step();
    step();
    chk("no_start_at_release", status, 32'h0);

    // Basic capture, then channel filter with noisy neighbours.
    do_start(9'd5);
    stream_capture(1'b0);
    chk("basic_done", status, 32'h4000_0000);
    step();
    chk("basic_writes", wr_cnt, 4);
    do_start(9'd5);
    stream_capture(1'b1);
    chk("filter_done", status, 32'h4000_0000);
    step();
    chk("filter_writes", wr_cnt, 4);

    // Rounding, clamp and negative paths, with a start toggle mid-RUN.
    do_start(9'd7);
    feed_point(9'd7, 1, 1, 1, 0, 10, 20, 30, 41, 1'b1);
    feed_point(9'd7, 32767, 32767, 32767, 32767, -1, -1, -1, 0, 1'b0);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("toggle_in_run", status, 32'h8000_0002);
    feed_point(9'd7, -32768, -32768, -32768, -32768, 5, 5, 5, 6, 1'b1);
    feed_point(9'd7, -5, -6, 7, 1, 32767, 32767, 32767, 32767, 1'b0);
    chk("round_done", status, 32'h4000_0000);
    step();
    chk("round_writes", wr_cnt, 4);

    // Abort after two points, with a completing sample in the clr cycle.
    do_start(9'd3);
    feed_point(9'd3, 8, 8, 8, 8, -8, -8, -8, -8, 1'b0);
    feed_point(9'd3, 9, 9, 9, 9, 3, 3, 3, 3, 1'b1);
    chk("pre_abort", status, 32'h8000_0002);
    send(9'd3, 1000, 1000);
    send(9'd3, 1000, 1000);
    send(9'd3, 1000, 1000);
    clr         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_ch    = 9'd3;
    bus.s_i     = 16'sd1000;
    bus.s_q     = 16'sd1000;
    step();
    clr         = 1'b0;
    bus.s_valid = 1'b0;
    chk("abort_status", status, 32'h0);
    chk("abort_no_we", bus.bram_we, 1'b0);

    do_start(9'd3);
    feed_point(9'd3, 4, 4, 4, 4, -12, -12, -12, -12, 1'b0);
    chk("restart_one", status, 32'h8000_0001);
    feed_point(9'd3, 1, 2, 3, 4, 0, 0, 0, 0, 1'b0);
    feed_point(9'd3, 0, 0, 0, 0, 1, 1, 1, 1, 1'b1);
    feed_point(9'd3, 100, 200, 300, 400, -2, -2, -2, -3, 1'b0);
    chk("restart_done", status, 32'h4000_0000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_clears_done", status, 32'h0);
    step();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
